// File: rtl/fpu_result_packer.sv
// fpu_result_packer: final FPU stage, packs IEEE-754 single words and
// status flags behind a registered valid/ready port with a 1-entry skid.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid / in_ready            upstream handshake (in_ready registered)
//   sign, rounding_mode            sign, 0 = nearest-even / 1 = toward zero
//   special_select                 00 normal, 01 zero, 10 inf, 11 NaN
//   invalid_in, inexact_in         upstream exception info
//   result_exponent                10-bit two's-complement biased exponent
//   result_fraction                xx.30 fraction, bit 30 = hidden bit
//   out_valid / out_ready          downstream handshake
//   result, flag_*                 packed word and status flags
//
// Optional macro FPU_FLUSH_TO_ZERO_EN: subnormal results flush to signed
// zero with underflow and inexact raised.

module fpu_result_packer #(
  parameter logic [31:0] QNAN_PATTERN = 32'h7FC0_0000,
  parameter int          MAX_EXP      = 254
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic        rounding_mode,
  input  logic [1:0]  special_select,
  input  logic        invalid_in,
  input  logic        inexact_in,
  input  logic [9:0]  result_exponent,
  input  logic [31:0] result_fraction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact,
  output logic        flag_invalid
);

  typedef struct packed {
    logic [31:0] word;
    logic        ovf;
    logic        unf;
    logic        inx;
    logic        inv;
  } pack_t;

  localparam logic signed [9:0] MAX_E = 10'(MAX_EXP);

  logic signed [9:0] e;
  logic              h;
  logic [22:0]       m;
  pack_t             pk;
  pack_t             out_q;
  pack_t             skid_q;
  logic              skid_full;
  logic              accept;
  logic              unused_bits;

  assign e = $signed(result_exponent);
  assign h = result_fraction[30];
  assign m = result_fraction[29:7];

  // Bit 31 never arrives set; low bits were consumed by rounding.
  assign unused_bits = ^{result_fraction[31], result_fraction[6:0]};

  always_comb begin
    pk = '0;
    unique case (special_select)
      2'b11: begin
        pk.word = QNAN_PATTERN;
        pk.inv  = invalid_in;
      end
      2'b10: pk.word = {sign, 8'hFF, 23'h0};
      2'b01: pk.word = {sign, 31'h0};
      default: begin
        if (!h) begin
`ifdef FPU_FLUSH_TO_ZERO_EN
          pk.word = {sign, 31'h0};
          if (m != '0) begin
            pk.unf = 1'b1;
            pk.inx = 1'b1;
          end else begin
            pk.inx = inexact_in;
          end
`else
          pk.word = {sign, 8'h00, m};
          pk.unf  = inexact_in & (m != '0);
          pk.inx  = inexact_in;
`endif
        end else if (e > MAX_E) begin
          // Toward-zero saturates to max finite instead of infinity.
          pk.word = rounding_mode ? {sign, 8'hFE, 23'h7FFFFF}
                                  : {sign, 8'hFF, 23'h0};
          pk.ovf  = 1'b1;
          pk.inx  = 1'b1;
        end else if (e >= 10'sd1) begin
          pk.word = {sign, e[7:0], m};
          pk.inx  = inexact_in;
        end else begin
          // Normalized fraction with non-positive exponent: defensive zero.
          pk.word = {sign, 31'h0};
          pk.unf  = 1'b1;
          pk.inx  = 1'b1;
        end
      end
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      skid_full <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (skid_full) begin
      // Output is necessarily valid here; refill it from the skid.
      if (out_ready) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
        in_ready  <= 1'b1;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_q     <= pk;
        out_valid <= 1'b1;
      end else begin
        skid_q    <= pk;
        skid_full <= 1'b1;
        in_ready  <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign result         = out_q.word;
  assign flag_overflow  = out_q.ovf;
  assign flag_underflow = out_q.unf;
  assign flag_inexact   = out_q.inx;
  assign flag_invalid   = out_q.inv;

endmodule

// File: doc/fpu_result_packer.md
Name: fpu_result_packer

Overview:
- Final pipeline stage, directly downstream of the rounding unit.
- Consumes the rounded, renormalized exponent/fraction pair plus sign, special-case select and upstream exception info.
- Produces the packed IEEE-754 single-precision word and sticky-free status flags.
- Registered output with valid/ready handshake and a one-entry skid buffer, so back-pressure never drops a result.

Parameters:
QNAN_PATTERN, 32'h7FC0_0000, packed word emitted for the NaN special case (sign ignored)
MAX_EXP, 254, largest biased exponent that packs as a finite normal

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept; registered
sign  input  1  result sign
rounding_mode  input  1  0 = nearest-even, 1 = toward zero
special_select  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
invalid_in  input  1  invalid-operation flag from operand classification
inexact_in  input  1  rounding discarded nonzero bits
result_exponent  input  10  two's-complement biased exponent from rounding unit
result_fraction  input  32  [xx.xxxx] format, 2 integer bits, 30 fraction bits; bit 30 = hidden bit
out_valid  output  1  packed result valid
out_ready  input  1  downstream accepts
result  output  32  packed IEEE single
flag_overflow  output  1
flag_underflow  output  1
flag_inexact  output  1
flag_invalid  output  1

Behaviour:
- Reset: out_valid=0, in_ready=1, result=0, all flags 0, skid entry empty. Reset mid-transfer discards both held entries.
- Pack function, combinational on the input side; e = signed result_exponent, h = result_fraction[30], m = result_fraction[29:7]:
  - special 11: result = QNAN_PATTERN; flag_invalid = invalid_in; all other flags 0.
  - special 10: {sign, 8'hFF, 23'h0}; no flags.
  - special 01: {sign, 31'h0}; no flags.
  - Normal path, overflow (e > MAX_EXP, h=1):
    - rounding_mode 0: {sign, 8'hFF, 0}.
    - rounding_mode 1: {sign, 8'hFE, 23'h7FFFFF}.
    - Both modes: flag_overflow=1, flag_inexact=1.
  - Normal path, h=1, 1 <= e <= MAX_EXP: {sign, e[7:0], m}; flag_inexact = inexact_in.
  - Normal path, h=0 (subnormal or zero): {sign, 8'h00, m}; flag_underflow = inexact_in & (m != 0); flag_inexact = inexact_in.
  - Normal path, h=1, e <= 0 (must not occur): signed zero with flag_underflow=1 and flag_inexact=1.
  - result_fraction[31]=1 is illegal input (upstream normalizer clears it). Pack ignores bit 31; the bench asserts it is never set.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Latency: 1 cycle from accepted input to out_valid when the output register is empty or draining.
  - in_ready = !skid_full, registered.
  - Accepted input while output register full and out_ready=0 goes to skid; skid_full=1 next cycle.
  - Output register drains (out_ready=1) with skid full: skid moves to output; in_ready returns to 1 next cycle.
  - Simultaneous accept and drain with skid empty: new word loads output register directly, out_valid stays 1.
  - Throughput: 1 result per cycle when out_ready held high.
  - result and flags stable while out_valid=1 and out_ready=0.
  - Ordering strictly FIFO.

Optional Feature:
FPU_FLUSH_TO_ZERO_EN
- Defined: any normal-path result with h=0 and m != 0 packs as {sign, 31'h0}, with flag_underflow=1 and flag_inexact=1 regardless of inexact_in.
- Undefined: subnormals pack as specified above.

Test Plan:
- Inputs e=127, fraction=32'h4000_0000, sign=0, special 00 -> result 32'h3F80_0000, no flags, out_valid one cycle after accept.
- e=255, h=1, sign=1: mode 0 -> 32'hFF80_0000; mode 1 -> 32'hFF7F_FFFF; both set overflow+inexact.
- h=0, fraction=32'h0000_0080, e=0, inexact_in=1 -> result 32'h0000_0001, underflow+inexact (with FPU_FLUSH_TO_ZERO_EN: 32'h0000_0000, underflow+inexact).
- special 11, invalid_in=1 -> 32'h7FC0_0000, flag_invalid=1; special 10, sign=1 -> 32'hFF80_0000.
- Back-pressure: 4 back-to-back inputs, out_ready=0 for 3 cycles -> in_ready drops after 2nd accept, no loss, 4 outputs in order once out_ready=1.
- reset asserted with both entries full -> next cycle out_valid=0, in_ready=1, result=0.
